// File: rtl/axis_adc_averager_if.sv
// AXI-Stream style handshake bundle used on both sides of the ADC averager.
// The master drives valid/data and samples ready; the slave does the reverse.
interface axis_adc_averager_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_adc_averager.sv
// Two-channel block averager for a packed ADC sample stream.
// Each input beat carries {chan_b, chan_a} as signed 16-bit samples. While
// 'run' is high, 2^AVG_LOG2 valid beats are summed per channel and the floor
// of the mean is emitted as a single output beat {avg_b, avg_a}.
// The upstream stage cannot be stalled, so a result arriving while the output
// slot is still held is dropped and counted in overflow_cnt.
// Optional feature: define AXIS_ADC_AVERAGER_ROUND_EN to round half up
// instead of truncating toward minus infinity.
module axis_adc_averager #(
  parameter int AVG_LOG2 = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      run,
  axis_adc_averager_if.slave        s_axis,
  axis_adc_averager_if.master       m_axis,
  output logic [15:0]               overflow_cnt
);

  localparam int N_SAMPLES = 1 << AVG_LOG2;
  // 16 + AVG_LOG2 bits hold the sum of 2^AVG_LOG2 signed 16-bit samples,
  // plus the rounding bias, without wrapping.
  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

`ifdef AXIS_ADC_AVERAGER_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'((1 << AVG_LOG2) >> 1);
`else
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = '0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_next;

  logic signed [15:0]        samp_a;
  logic signed [15:0]        samp_b;
  logic signed [ACC_W-1:0]   acc_a;
  logic signed [ACC_W-1:0]   acc_b;
  logic signed [ACC_W-1:0]   sum_a;
  logic signed [ACC_W-1:0]   sum_b;
  logic signed [ACC_W-1:0]   rnd_a;
  logic signed [ACC_W-1:0]   rnd_b;
  logic [CNT_W-1:0]          cnt;
  logic [31:0]               result;

  logic                      accept;
  logic                      result_fire;
  logic                      load_out;
  logic                      drop_out;

  assign s_axis.tready = 1'b1;

  assign samp_a = s_axis.tdata[15:0];
  assign samp_b = s_axis.tdata[31:16];

  assign sum_a  = acc_a + ACC_W'(samp_a);
  assign sum_b  = acc_b + ACC_W'(samp_b);
  assign rnd_a  = sum_a + ROUND_BIAS;
  assign rnd_b  = sum_b + ROUND_BIAS;

  assign result = {16'(rnd_b >>> AVG_LOG2), 16'(rnd_a >>> AVG_LOG2)};

  // State register: run is sampled at each edge, reset parks the block idle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-edge control: which samples count, when a block
  // completes, and whether its result can take the output slot.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    result_fire = 1'b0;
    load_out    = 1'b0;
    drop_out    = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (!run) begin
          state_next = IDLE;
        end
        accept = s_axis.tvalid;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    result_fire = accept && (cnt == LAST_CNT);
    load_out    = result_fire && (!m_axis.tvalid || m_axis.tready);
    drop_out    = result_fire && m_axis.tvalid && !m_axis.tready;
  end

  // Accumulators and sample counter: cleared while idle and after each
  // completed block so every result covers exactly one fresh block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (cnt == LAST_CNT) begin
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  // Single-entry output slot: a new result replaces an empty or departing
  // beat; otherwise the held beat stays frozen until the consumer takes it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
    end else if (load_out) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= result;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

  // Dropped-result counter, sticking at its maximum rather than wrapping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow_cnt <= '0;
    end else if (drop_out && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_adc_averager.sv
// Self-checking bench for axis_adc_averager with AVG_LOG2 = 4.
// Inputs change on the falling edge; outputs are compared on the next
// falling edge against a block-level reference model (sample queues and
// plain integer floor division) and, for the fixed scenarios, against
// hand-computed constants.
module tb_axis_adc_averager;

  localparam int AVG_LOG2 = 4;
  localparam int N = 1 << AVG_LOG2;
  localparam bit ROUND =
`ifdef AXIS_ADC_AVERAGER_ROUND_EN
    1'b1;
`else
    1'b0;
`endif

  logic        aclk;
  logic        areset;
  logic        run;
  logic [15:0] overflow_cnt;

  axis_adc_averager_if s_if ();
  axis_adc_averager_if m_if ();

  axis_adc_averager #(.AVG_LOG2(AVG_LOG2)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .run          (run),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .overflow_cnt (overflow_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int vec_count   = 0;
  int miscompares = 0;

  // Reference model state.
  bit          mdl_accum;
  int          qa[$];
  int          qb[$];
  bit          mdl_valid;
  logic [31:0] mdl_data;
  int          mdl_ovf;

  typedef struct {
    int a0; int a1; int b0; int b1;
    int ea_trunc; int ea_round; int eb_trunc; int eb_round;
  } vec_t;

  vec_t tbl[5];

  // Mean of one block, floor or round-half-up, using plain integer math.
  function automatic logic [15:0] avg_of(input int sum);
    int s;
    int q;
    s = sum + (ROUND ? N / 2 : 0);
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q[15:0];
  endfunction

  function automatic void modelReset();
    mdl_accum = 1'b0;
    qa.delete();
    qb.delete();
    mdl_valid = 1'b0;
    mdl_data  = '0;
    mdl_ovf   = 0;
  endfunction

  // One clock edge of the model, given the inputs present at that edge.
  function automatic void modelEdge(input bit r, input bit v, input int a, input int b, input bit rdy);
    bit          fire;
    logic [31:0] res;
    int          sa;
    int          sb;
    fire = 1'b0;
    res  = '0;
    if (mdl_accum) begin
      if (v) begin
        qa.push_back(a);
        qb.push_back(b);
        if (qa.size() == N) begin
          sa = 0;
          sb = 0;
          foreach (qa[i]) sa += qa[i];
          foreach (qb[i]) sb += qb[i];
          res  = {avg_of(sb), avg_of(sa)};
          fire = 1'b1;
          qa.delete();
          qb.delete();
        end
      end
    end else begin
      qa.delete();
      qb.delete();
    end
    if (fire) begin
      if (!mdl_valid || rdy) begin
        mdl_valid = 1'b1;
        mdl_data  = res;
      end else if (mdl_ovf < 65535) begin
        mdl_ovf++;
      end
    end else if (rdy) begin
      mdl_valid = 1'b0;
    end
    mdl_accum = r;
  endfunction

  task automatic checkOutput(input string name, input bit ev, input logic [31:0] ed, input logic [15:0] eo);
    vec_count++;
    if (m_if.tvalid !== ev || m_if.tdata !== ed || overflow_cnt !== eo || s_if.tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got valid=%0b data=%h ovf=%0d s_ready=%0b, expected valid=%0b data=%h ovf=%0d s_ready=1",
               name, $time, m_if.tvalid, m_if.tdata, overflow_cnt, s_if.tready, ev, ed, eo);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, advance the model at the
  // rising edge and compare at the following falling edge.
  task automatic applyStimulus(input bit r, input bit v, input int a, input int b, input bit rdy);
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    run          = r;
    s_if.tvalid  = v;
    s_if.tdata   = {bv[15:0], av[15:0]};
    m_if.tready  = rdy;
    @(posedge aclk);
    modelEdge(r, v, a, b, rdy);
    @(negedge aclk);
    checkOutput("step", mdl_valid, mdl_data, 16'(mdl_ovf));
  endtask

  // Asynchronous reset pulse between clock edges; its effect is checked
  // before any rising edge occurs.
  task automatic doReset();
    areset = 1'b1;
    #2;
    modelReset();
    checkOutput("reset", 1'b0, 32'h0, 16'h0);
    #1;
    areset = 1'b0;
  endtask

  task automatic feed(input int count, input int a, input int b, input bit rdy);
    for (int k = 0; k < count; k++) applyStimulus(1'b1, 1'b1, a, b, rdy);
  endtask

  initial begin
    logic [15:0] ea;
    logic [15:0] eb;
    logic [31:0] held;

    tbl[0] = '{100, 100, -100, -100, 100, 100, -100, -100};
    tbl[1] = '{0, 1, 0, -1, 0, 1, -1, 0};
    tbl[2] = '{32767, 32767, -32768, -32768, 32767, 32767, -32768, -32768};
    tbl[3] = '{3, 4, -3, -4, 3, 4, -4, -3};
    tbl[4] = '{1000, -1000, 7, 8, 0, 0, 7, 8};

    areset      = 1'b1;
    run         = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    modelReset();
    @(negedge aclk);
    doReset();

    // Table of alternating-sample blocks with known averages.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) begin
        applyStimulus(1'b1, 1'b1, (k % 2 == 0) ? tbl[i].a0 : tbl[i].a1,
                      (k % 2 == 0) ? tbl[i].b0 : tbl[i].b1, 1'b1);
        if (k == N - 2) checkOutput("table_pre", 1'b0, m_if.tdata, 16'h0);
      end
      ea = 16'(ROUND ? tbl[i].ea_round : tbl[i].ea_trunc);
      eb = 16'(ROUND ? tbl[i].eb_round : tbl[i].eb_trunc);
      checkOutput("table", 1'b1, {eb, ea}, 16'h0);
    end

    // Held output under backpressure: second result dropped and counted.
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    feed(16, 20, -20, 1'b0);
    feed(24, 77, 77, 1'b0);
    checkOutput("hold", 1'b1, 32'hFFEC0014, 16'd1);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    checkOutput("accept", 1'b0, 32'hFFEC0014, 16'd1);

    // New result on the same edge the pending beat is accepted.
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    feed(16, 11, 22, 1'b0);
    feed(15, -5, 6, 1'b0);
    applyStimulus(1'b1, 1'b1, -5, 6, 1'b1);
    checkOutput("coincide", 1'b1, 32'h0006FFFB, 16'd0);

    // Reset mid-block discards the partial sum.
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    feed(7, -999, -999, 1'b1);
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    feed(16, 5, 5, 1'b1);
    checkOutput("post_reset", 1'b1, 32'h00050005, 16'd0);

    // Dropping run mid-block keeps the pending beat and restarts the block.
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    feed(16, 40, -40, 1'b0);
    held = 32'hFFD80028;
    feed(10, -500, -500, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, -500, -500, 1'b0);
    checkOutput("run_low", 1'b1, held, 16'd0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    feed(16, 9, -9, 1'b1);
    checkOutput("restart", 1'b1, 32'hFFF70009, 16'd0);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768,
                      $urandom_range(0, 2) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
